// File: rtl/inst_seq_param_if.sv
// Bundle between decode/control (master) and the instruction cycle sequencer (slave).
// The master drives the advance/fetch controls; the slave returns the T-state view.
interface inst_seq_param_if #(
   parameter int CYCLES = 8,
   parameter int IDX_W  = 3,
   parameter int CNT_W  = 16
);
   logic              rdy;
   logic              next_sync;
   logic              ovr_clr;
   logic [CYCLES-1:0] cycle;
   logic [IDX_W-1:0]  cycle_idx;
   logic              sync;
   logic              last;
   logic              overrun;
   logic [CNT_W-1:0]  inst_count;

   modport master (
      output rdy, next_sync, ovr_clr,
      input  cycle, cycle_idx, sync, last, overrun, inst_count
   );

   modport slave (
      input  rdy, next_sync, ovr_clr,
      output cycle, cycle_idx, sync, last, overrun, inst_count
   );
endinterface

// File: rtl/inst_seq_param.sv
// Per-instruction T-state sequencer: one-hot and binary T-state, registered SYNC,
// RDY stall, sticky overrun flag and a retired-instruction counter.
module inst_seq_param #(
   parameter int CYCLES = 8,
   parameter int IDX_W  = 3,
   parameter int CNT_W  = 16
) (
   input logic              clk,
   input logic              reset,
   inst_seq_param_if.slave  bus
);
   localparam logic [CYCLES-1:0] T0_ONEHOT = CYCLES'(1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CYCLES - 1);

   logic [CYCLES-1:0] r_cycle;
   logic [IDX_W-1:0]  r_cycle_idx;
   logic              r_sync;
   logic              r_overrun;
   logic [CNT_W-1:0]  r_inst_count;

   logic [CYCLES-1:0] w_cycle_next;
   logic [IDX_W-1:0]  w_cycle_idx_next;
   logic              w_sync_next;
   logic              w_overrun_next;
   logic [CNT_W-1:0]  w_inst_count_next;
   logic [CYCLES-1:0] w_shifted;
   logic              w_at_last;
   logic              w_dead;

   // Advance the one-hot by one T-state; the top bit falls off into the dead state.
   assign w_shifted[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < CYCLES; gi++) begin : g_shift
         assign w_shifted[gi] = r_cycle[gi-1];
      end
   endgenerate

   assign w_at_last = r_cycle[CYCLES-1];
   assign w_dead    = (r_cycle == '0);

   always_comb begin
      w_cycle_next      = r_cycle;
      w_cycle_idx_next  = r_cycle_idx;
      w_sync_next       = r_sync;
      w_inst_count_next = r_inst_count;
      w_overrun_next    = r_overrun;

      // Clear is honoured even while stalled; a same-cycle set overrides it below.
      if (bus.ovr_clr) begin
         w_overrun_next = 1'b0;
      end

      if (bus.rdy) begin
         if (bus.next_sync) begin
            w_cycle_next      = T0_ONEHOT;
            w_cycle_idx_next  = '0;
            w_sync_next       = 1'b1;
            w_inst_count_next = r_inst_count + CNT_W'(1);
         end else begin
            w_sync_next  = 1'b0;
            w_cycle_next = w_shifted;
            if (w_at_last) begin
               w_cycle_idx_next = IDX_LAST;
               w_overrun_next   = 1'b1;
            end else if (!w_dead) begin
               w_cycle_idx_next = r_cycle_idx + IDX_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle      <= T0_ONEHOT;
         r_cycle_idx  <= '0;
         r_sync       <= 1'b1;
         r_overrun    <= 1'b0;
         r_inst_count <= '0;
      end else begin
         r_cycle      <= w_cycle_next;
         r_cycle_idx  <= w_cycle_idx_next;
         r_sync       <= w_sync_next;
         r_overrun    <= w_overrun_next;
         r_inst_count <= w_inst_count_next;
      end
   end

   assign bus.cycle      = r_cycle;
   assign bus.cycle_idx  = r_cycle_idx;
   assign bus.sync       = r_sync;
   assign bus.last       = r_cycle[CYCLES-1];
   assign bus.overrun    = r_overrun;
   assign bus.inst_count = r_inst_count;
endmodule

// File: tb/tb_inst_seq_param.sv
// Directed bench for inst_seq_param (CYCLES=8, IDX_W=3, CNT_W=4 so the counter wrap is short).
module tb_inst_seq_param;
   localparam int CYCLES = 8;
   localparam int IDX_W  = 3;
   localparam int CNT_W  = 4;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;
   int   exp_cnt;

   inst_seq_param_if #(.CYCLES(CYCLES), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   inst_seq_param #(.CYCLES(CYCLES), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] cyc, input logic [2:0] idx,
                          input logic snc, input logic ovr, input int cnt);
      chk({tag, ".cycle"},      32'(bus.cycle),      32'(cyc));
      chk({tag, ".cycle_idx"},  32'(bus.cycle_idx),  32'(idx));
      chk({tag, ".sync"},       32'(bus.sync),       32'(snc));
      chk({tag, ".last"},       32'(bus.last),       32'(cyc[7]));
      chk({tag, ".overrun"},    32'(bus.overrun),    32'(ovr));
      chk({tag, ".inst_count"}, 32'(bus.inst_count), 32'(cnt[3:0]));
      $display("step %-12s cycle=%02h idx=%0d sync=%0b last=%0b ovr=%0b cnt=%0h",
               tag, bus.cycle, bus.cycle_idx, bus.sync, bus.last, bus.overrun, bus.inst_count);
   endtask

   initial begin
      n_pass = 0; n_total = 0; exp_cnt = 0;
      reset = 1'b1; bus.rdy = 1'b0; bus.next_sync = 1'b0; bus.ovr_clr = 1'b0;

      // Reset for two clocks
      step(); step();
      chk_all("reset", 8'h01, 3'd0, 1'b1, 1'b0, 0);

      // Fetch every 4th clock: 01,02,04,08,01,...
      reset = 1'b0; bus.rdy = 1'b1;
      for (int p = 0; p < 2; p++) begin
         bus.next_sync = 1'b0;
         step(); chk_all("seq.t1", 8'h02, 3'd1, 1'b0, 1'b0, exp_cnt);
         step(); chk_all("seq.t2", 8'h04, 3'd2, 1'b0, 1'b0, exp_cnt);
         step(); chk_all("seq.t3", 8'h08, 3'd3, 1'b0, 1'b0, exp_cnt);
         bus.next_sync = 1'b1;
         step(); exp_cnt++;
         chk_all("seq.t0", 8'h01, 3'd0, 1'b1, 1'b0, exp_cnt);
      end

      // Stall at T2 with next_sync asserted: nothing moves
      bus.next_sync = 1'b0;
      step(); step();
      chk_all("stall.pre", 8'h04, 3'd2, 1'b0, 1'b0, exp_cnt);
      bus.rdy = 1'b0; bus.next_sync = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(); chk_all("stall.hold", 8'h04, 3'd2, 1'b0, 1'b0, exp_cnt);
      end
      bus.rdy = 1'b1; bus.next_sync = 1'b0;
      step(); chk_all("stall.resume", 8'h08, 3'd3, 1'b0, 1'b0, exp_cnt);

      // Run off the end of the T-states
      bus.next_sync = 1'b1;
      step(); exp_cnt++;
      chk_all("ovr.t0", 8'h01, 3'd0, 1'b1, 1'b0, exp_cnt);
      bus.next_sync = 1'b0;
      for (int k = 1; k < 8; k++) begin
         step(); chk_all("ovr.shift", 8'(1 << k), 3'(k), 1'b0, 1'b0, exp_cnt);
      end
      step(); chk_all("ovr.dead", 8'h00, 3'd7, 1'b0, 1'b1, exp_cnt);
      step(); chk_all("ovr.dead2", 8'h00, 3'd7, 1'b0, 1'b1, exp_cnt);
      bus.next_sync = 1'b1;
      step(); exp_cnt++;
      chk_all("ovr.refetch", 8'h01, 3'd0, 1'b1, 1'b1, exp_cnt);

      // Clear alone, then set and clear together (set wins)
      bus.ovr_clr = 1'b1;
      step(); exp_cnt++;
      chk_all("clr.alone", 8'h01, 3'd0, 1'b1, 1'b0, exp_cnt);
      bus.ovr_clr = 1'b0; bus.next_sync = 1'b0;
      for (int k = 0; k < 7; k++) step();
      chk_all("clr.at_last", 8'h80, 3'd7, 1'b0, 1'b0, exp_cnt);
      bus.ovr_clr = 1'b1;
      step(); chk_all("clr.set_wins", 8'h00, 3'd7, 1'b0, 1'b1, exp_cnt);
      step(); chk_all("clr.dead", 8'h00, 3'd7, 1'b0, 1'b0, exp_cnt);
      bus.ovr_clr = 1'b0;
      step(); chk_all("clr.no_reflag", 8'h00, 3'd7, 1'b0, 1'b0, exp_cnt);

      // Clear while stalled: fetch, overrun again, then clear with rdy=0
      bus.next_sync = 1'b1;
      step(); exp_cnt++;
      bus.next_sync = 1'b0;
      for (int k = 0; k < 8; k++) step();
      chk_all("clr.rearm", 8'h00, 3'd7, 1'b0, 1'b1, exp_cnt);
      bus.rdy = 1'b0; bus.ovr_clr = 1'b1;
      step(); chk_all("clr.stalled", 8'h00, 3'd7, 1'b0, 1'b0, exp_cnt);
      bus.ovr_clr = 1'b0; bus.rdy = 1'b1;

      // Counter wrap: count up to 4'hF, then one more wraps to 0
      bus.next_sync = 1'b1;
      while (exp_cnt < 15) begin
         step(); exp_cnt++;
         chk_all("cnt.inc", 8'h01, 3'd0, 1'b1, 1'b0, exp_cnt);
      end
      step(); exp_cnt = 0;
      chk_all("cnt.wrap", 8'h01, 3'd0, 1'b1, 1'b0, exp_cnt);

      // Reset during a stall at T4
      bus.next_sync = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk_all("rst.t4", 8'h10, 3'd4, 1'b0, 1'b0, exp_cnt);
      bus.rdy = 1'b0;
      step(); chk_all("rst.hold", 8'h10, 3'd4, 1'b0, 1'b0, exp_cnt);
      reset = 1'b1;
      step(); chk_all("rst.mid_stall", 8'h01, 3'd0, 1'b1, 1'b0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
